// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one banked scratchpad port with lockstep read-pipeline tracking
module mem_port_arbiter #(
  parameter int DATA_L     = 32,
  parameter int ADDR_L     = 10,
  parameter int N_BANKS    = 8,
  parameter int N_REQ      = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       req_valid,
  input  logic [N_REQ-1:0]                       req_we,
  input  logic [N_REQ-1:0][ADDR_L-1:0]           req_addr,
  input  logic [N_REQ-1:0][N_BANKS-1:0]          req_wr_mask,
  input  logic [N_REQ-1:0][N_BANKS-1:0][DATA_L-1:0] req_wr_data,
  output logic [N_REQ-1:0]                       req_ready,
  output logic [N_REQ-1:0]                       rsp_valid,
  output logic [N_BANKS-1:0][DATA_L-1:0]         rsp_data,
  output logic [ADDR_L-1:0]                      mem_addr,
  output logic [N_BANKS-1:0]                     mem_wr_en,
  output logic [N_BANKS-1:0]                     mem_rd_en,
  output logic [N_BANKS-1:0][DATA_L-1:0]         mem_wr_data,
  input  logic [N_BANKS-1:0][DATA_L-1:0]         mem_rd_data,
  output logic                                   busy
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr, gid, cur_id;
  logic hit, act, cur_rd, fresh, pend;
  logic [RD_LATENCY-1:0] tv;
  logic [RD_LATENCY-1:0][IW-1:0] tid;
  logic [RD_LATENCY:0] ext;
  assign act = |(mem_wr_en | mem_rd_en);
  assign ext = {tv, cur_rd};
  assign rsp_data = mem_rd_data;
  always_comb begin
    hit = 1'b0;
    gid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!hit && !rst && req_valid[(int'(ptr) + k) % N_REQ]) begin
        hit = 1'b1;
        gid = IW'((int'(ptr) + k) % N_REQ);
      end
    end
    req_ready = hit ? N_REQ'(1) << gid : '0;
  end
  // pend: after the coming edge some read would still sit short of the last stage
  always_comb begin
    pend = 1'b0;
    busy = cur_rd | (fresh & tv[RD_LATENCY-1]);
    for (int j = 0; j < RD_LATENCY - 1; j++) begin
      pend = pend | (act ? ext[j] : ext[j+1]);
      busy = busy | tv[j];
    end
    for (int r = 0; r < N_REQ; r++)
      rsp_valid[r] = fresh && tv[RD_LATENCY-1] && tid[RD_LATENCY-1] == IW'(r);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      mem_addr    <= '0;
      mem_wr_en   <= '0;
      mem_rd_en   <= '0;
      mem_wr_data <= '0;
      cur_rd      <= 1'b0;
      cur_id      <= '0;
      tv          <= '0;
      tid         <= '0;
      fresh       <= 1'b0;
    end else begin
      if (hit) begin
        ptr         <= IW'((int'(gid) + 1) % N_REQ);
        mem_addr    <= req_addr[gid];
        mem_wr_data <= req_wr_data[gid];
        mem_wr_en   <= req_we[gid] ? req_wr_mask[gid] : '0;
        mem_rd_en   <= req_we[gid] ? ~req_wr_mask[gid] : '1;
        cur_rd      <= !req_we[gid];
        cur_id      <= gid;
      end else begin
        mem_wr_en   <= '0;
        mem_rd_en   <= {N_BANKS{pend}};
        cur_rd      <= 1'b0;
      end
      fresh <= act;
      if (act) begin
        tv[0]  <= cur_rd;
        tid[0] <= cur_id;
        for (int i = 1; i < RD_LATENCY; i++) begin
          tv[i]  <= tv[i-1];
          tid[i] <= tid[i-1];
        end
      end
    end
  end
endmodule
